// File: rtl/ahb_sync_req_tx.sv
// ahb_sync_req_tx: initiator side of a req/ack register-transfer handshake.
// The receiver lives in another clock domain and answers with an asynchronous
// ack pulse.
//
// Ports:
//   HCLK, HRESET          block clock and synchronous active-high reset
//   start                 one-cycle send request; honoured only while busy = 0
//   DADR_IN/CADR_IN/DLEN_IN  values captured on an accepted start
//   ack_in                receiver ack, asynchronous to HCLK
//   req                   registered handshake request
//   DADR/CADR/DLEN        registered held values, stable while req is high
//   busy                  high whenever the FSM is not idle
//   done / err            one-cycle pulses: ack seen / timed out waiting for ack
module ahb_sync_req_tx #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GUARD_CYCLES   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] DADR_IN,
  input  logic [ADDR_WIDTH-1:0] CADR_IN,
  input  logic [1:0]            DLEN_IN,
  input  logic                  ack_in,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] DADR,
  output logic [ADDR_WIDTH-1:0] CADR,
  output logic [1:0]            DLEN,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES
                                                                      : GUARD_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles);

  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] GuardLast   = TimerW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGuard
  } state_e;

  state_e                  state_q;
  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   dadr_q;
  logic [ADDR_WIDTH-1:0]   cadr_q;
  logic [1:0]              dlen_q;
  logic                    done_q;
  logic                    err_q;
  logic                    ack_s1_q;
  logic                    ack_s2_q;
  logic                    ack_s3_q;
  logic [TimerW-1:0]       timer_q;
  logic                    ack_rise;

  // s1/s2 form the synchroniser; s3 only remembers s2 for edge detection.
  assign ack_rise = ack_s2_q & ~ack_s3_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      dadr_q   <= '0;
      cadr_q   <= '0;
      dlen_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      ack_s1_q <= ack_in;
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
      done_q   <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start) begin
            dadr_q  <= DADR_IN;
            cadr_q  <= CADR_IN;
            dlen_q  <= DLEN_IN;
            req_q   <= 1'b1;
            timer_q <= '0;
            state_q <= StReq;
          end
        end

        StReq: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (ack_rise) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            timer_q <= '0;
            state_q <= StGuard;
          end else if (timer_q == TimeoutLast) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            timer_q <= '0;
            state_q <= StGuard;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StGuard: begin
          // Return-to-zero interval; late acks and new starts are dropped here.
          if (timer_q == GuardLast) begin
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        default: begin
          req_q   <= 1'b0;
          timer_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req  = req_q;
  assign DADR = dadr_q;
  assign CADR = cadr_q;
  assign DLEN = dlen_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign err  = err_q;

endmodule
